// File: rtl/tnn_pkg.sv
// Shared types for the ternary neuron datapath.
// Trit encoding and FSM states used by accum and layer-output stages.
package tnn_pkg;

  localparam int ACC_W_DEF = 10;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    TRIT_ZERO = 2'b00,
    TRIT_POS  = 2'b01,
    TRIT_NEG  = 2'b11
  } trit_t;

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/tnn_threshold.sv
// Combinational ternary threshold: signed acc vs. hi/lo bounds.
// Bounds are inclusive; hi wins if both would match.
module tnn_threshold
  import tnn_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output trit_t            trit
);

  always_comb begin
    trit = TRIT_ZERO;
    if ($signed(acc) >= $signed(thr_hi))
      trit = TRIT_POS;
    else if ($signed(acc) <= $signed(thr_lo))
      trit = TRIT_NEG;
  end

endmodule

// File: rtl/tnn_neuron_accum.sv
// Multi-beat ternary neuron: saturating signed accumulate of
// (pos - neg) popcounts, then threshold into a held activation.
module tnn_neuron_accum
  import tnn_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_BEATS = 8,
  parameter int BEAT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] pos_cnt,
  input  logic [CNT_W-1:0] neg_cnt,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_trit,
  output logic             out_sat,
  output logic             out_err
);

  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] ACC_MAX =
    SW'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX;
  localparam logic [BEAT_W-1:0] BEAT_END = BEAT_W'(MAX_BEATS);

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic        [BEAT_W-1:0]  beat;
  logic                      sat;
  logic                      in_ready_q;
  logic                      out_valid_q;
  trit_t                     trit_q;
  logic                      sat_q;
  logic                      err_q;

  logic signed [CNT_W:0]     d_raw;
  logic signed [SW-1:0]      d_ext;
  logic signed [SW-1:0]      sum;
  logic signed [ACC_W-1:0]   acc_nx;
  logic                      clip;
  logic        [BEAT_W-1:0]  beat_nx;
  logic                      at_max;
  logic                      take;
  logic                      done;
  trit_t                     trit_nx;

  assign d_raw = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
  assign d_ext = SW'(d_raw);
  assign sum   = SW'(acc) + d_ext;

  // One extra bit of headroom lets the clamp see the true sum.
  always_comb begin
    acc_nx = sum[ACC_W-1:0];
    clip   = 1'b0;
    if (sum > ACC_MAX) begin
      acc_nx = ACC_MAX[ACC_W-1:0];
      clip   = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_nx = ACC_MIN[ACC_W-1:0];
      clip   = 1'b1;
    end
  end

  assign beat_nx = beat + 1'b1;
  assign at_max  = (beat_nx == BEAT_END);
  assign take    = in_valid & in_ready_q;
  assign done    = take & (in_last | at_max);

  tnn_threshold #(
    .ACC_W(ACC_W)
  ) u_thr (
    .acc    (acc_nx),
    .thr_hi (thr_hi),
    .thr_lo (thr_lo),
    .trit   (trit_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACC;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc         <= '0;
      beat        <= '0;
      sat         <= 1'b0;
      trit_q      <= TRIT_ZERO;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (done) begin
            state       <= ST_HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            trit_q      <= trit_nx;
            sat_q       <= sat | clip;
            err_q       <= at_max & ~in_last;
            acc         <= '0;
            beat        <= '0;
            sat         <= 1'b0;
          end else if (take) begin
            acc  <= acc_nx;
            beat <= beat_nx;
            sat  <= sat | clip;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state       <= ST_ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_trit  = trit_q;
  assign out_sat   = sat_q;
  assign out_err   = err_q;

endmodule

// File: doc/tnn_neuron_accum.md
# tnn_neuron_accum

Sequential ternary-neuron back end placed directly downstream of the 18-input popcount units. Each beat carries one 18-input chunk as two popcounts: positive-weight matches and negative-weight matches. The block accumulates the signed difference over a multi-beat neuron evaluation, then applies two signed thresholds. It emits one ternary activation per neuron over a valid/ready handshake.

## Interface
Parameters:
- CNT_W, 5: width of each popcount input; legal values 0..18.
- ACC_W, 10: signed accumulator width.
- MAX_BEATS, 8: maximum number of chunks per neuron.
- BEAT_W, 4: beat counter width; must satisfy 2^BEAT_W > MAX_BEATS.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- thr_hi, input, ACC_W: signed upper threshold; quasi-static.
- thr_lo, input, ACC_W: signed lower threshold; quasi-static; thr_lo < thr_hi.
- in_valid, input, 1: beat valid.
- in_ready, output, 1: beat accepted when in_valid && in_ready.
- pos_cnt, input, CNT_W: positive popcount.
- neg_cnt, input, CNT_W: negative popcount.
- in_last, input, 1: final chunk of the current neuron.
- out_valid, output, 1: activation valid.
- out_ready, input, 1: downstream accepts.
- out_trit, output, 2: activation, encoded 01=+1, 11=-1, 00=0.
- out_sat, output, 1: accumulator saturated during this neuron.
- out_err, output, 1: MAX_BEATS reached without in_last.

## Operation
- The FSM has two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset state is ACC with acc=0, beat=0, sat=0, err=0. Reset values of the outputs: out_valid=0, out_trit=00, out_sat=0, out_err=0, in_ready=1.
- Per accepted beat: d = pos_cnt − neg_cnt, sign-extended to ACC_W; acc_next = acc + d.
- Saturation: acc_next is clamped to [−(2^(ACC_W−1)−1), 2^(ACC_W−1)−1]. The clamp sets sat, which is sticky for the current neuron.
- Out-of-range counts are not checked; pos_cnt or neg_cnt > 18 is used as given.
- An accepted beat with in_last=1, or the beat that makes beat==MAX_BEATS, moves the FSM to HOLD.
  - In the MAX_BEATS case with in_last=0, err is set.
- On that transition out_trit registers the threshold of acc_next: +1 if acc_next ≥ thr_hi, −1 if acc_next ≤ thr_lo, else 0. The sat and err values that include the final beat register into out_sat and out_err.
- acc, beat, sat and err clear on entry to HOLD.
- HOLD → ACC when out_ready=1. out_trit, out_sat and out_err stay stable while out_valid && !out_ready.
- A single-beat neuron is legal: in_last on the first beat.
- Asynchronous reset mid-neuron or in HOLD discards the partial result; no output is produced for it.

## Timing
- out_valid asserts the cycle after the final beat is accepted. Latency is 1 cycle.
- in_ready deasserts in that same cycle and reasserts the cycle after out_valid && out_ready.
- Throughput is N+1 cycles per N-beat neuron when out_ready is held at 1.
- Thresholds are sampled only on the final-beat edge.
- There is no combinational path from in_valid or out_ready to any output except through the registered state.

## Structure
- Package tnn_pkg holds:
  - trit_t, a 2-bit enum with TRIT_ZERO=2'b00, TRIT_POS=2'b01, TRIT_NEG=2'b11.
  - ACC_W and CNT_W defaults.
  - the state enum {ST_ACC, ST_HOLD}.
- Sub-module tnn_threshold is purely combinational: (acc, thr_hi, thr_lo) → trit_t. It is reused by the later layer-output stage.
- The top module holds the FSM, the saturating adder and the beat counter.

## Test plan
- Single beat: thr_hi=3, thr_lo=−3, pos=10, neg=2, last=1 → next cycle out_valid=1, out_trit=01, out_sat=0, out_err=0.
- Three beats (pos,neg) = (5,9), (0,7), (4,4), last on beat 3 → acc=−11, out_trit=11 one cycle after beat 3.
- Equality at the bounds: acc ending at exactly thr_hi=6 → 01. acc ending at thr_lo=−6 → 11. acc ending at 5 → 00.
- Backpressure: hold out_ready=0 for 5 cycles → in_ready=0 throughout, out_trit stable. Raise out_ready → in_ready=1 the next cycle and a new neuron is accepted.
- Overflow: ACC_W=6, eight beats of (18,0) with MAX_BEATS=8 and in_last=0 → acc clamps at 31, out_trit=01, out_sat=1, out_err=1.
- Reset mid-neuron: two beats accepted, then rst_n pulsed low → out_valid=0, in_ready=1. The next single beat (3,3) with last=1 gives out_trit=00, proving acc was cleared.
